rotating_priority_resolver: RTL and testbench
=============================================

ROTATING_PRIORITY_RESOLVER -- requirements
Module: rotating_priority_resolver

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt lines (legal 2..32).
REQ-002 SHALL have parameter EDGE_TRIG, default 0, 0 = level-triggered IRR, 1 = rising-edge-triggered IRR.
REQ-003 SHALL derive localparam IDW = clog2(NUM_IRQ), minimum 1, as the width of all level IDs.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port irq_req  input  NUM_IRQ  raw interrupt request lines.
REQ-007 SHALL have port imr  input  NUM_IRQ  mask, 1 = line masked.
REQ-008 SHALL have port rotate_mode  input  1  0 = fully nested, 1 = automatic rotation on non-specific EOI.
REQ-009 SHALL have port special_mask  input  1  1 = in-service levels do not block other levels.
REQ-010 SHALL have port ack  input  1  one-cycle acknowledge pulse for the presented interrupt.
REQ-011 SHALL have port eoi  input  1  non-specific end-of-interrupt pulse.
REQ-012 SHALL have ports seoi  input  1 and seoi_id  input  IDW  specific EOI for level seoi_id.
REQ-013 SHALL have ports set_prio  input  1 and prio_id  input  IDW  load level prio_id as lowest priority.
REQ-014 SHALL have ports int_req  output  1 and int_id  output  IDW  registered pending-interrupt indication and level.
REQ-015 SHALL have ports irr, isr  output  NUM_IRQ each, and lowest_prio  output  IDW  internal state, registered.

Function
REQ-016 Priority order SHALL be lowest_prio+1 (highest) through lowest_prio (lowest), modulo NUM_IRQ.
REQ-017 Level mode: irr[i] SHALL load registered irq_req[i] each cycle, except cleared in an ack cycle that grants i.
REQ-018 Edge mode: irr[i] SHALL set on a sampled 0->1 of irq_req[i] and hold until cleared by an ack granting i.
REQ-019 Candidate set SHALL be irr & ~imr; winner = highest-priority candidate.
REQ-020 Without special_mask, winner SHALL be presented only if strictly higher priority than highest-priority isr bit; with special_mask, isr bits SHALL be ignored.
REQ-021 int_req/int_id SHALL register the winner one cycle after irr; end-to-end latency irq_req edge -> int_req = 2 cycles; int_id holds 0 when int_req = 0.
REQ-022 ack with int_req = 1 SHALL set isr[int_id] and clear irr[int_id]; ack with int_req = 0 SHALL be ignored.
REQ-023 eoi SHALL clear highest-priority isr bit; if rotate_mode = 1, lowest_prio SHALL become that level; eoi with isr = 0 SHALL change nothing.
REQ-024 seoi SHALL clear isr[seoi_id] without rotation; seoi_id >= NUM_IRQ SHALL be ignored.
REQ-025 Simultaneous events SHALL resolve in order: EOI/seoi on current isr first, then ack set; set_prio SHALL override any rotation in the same cycle.
REQ-026 eoi and seoi together SHALL apply both clears in one cycle.
REQ-027 int_req SHALL deassert on the cycle after ack and re-evaluate from updated state.

Reset
REQ-028 rst_n low SHALL asynchronously force irr = 0, isr = 0, int_req = 0, int_id = 0, lowest_prio = NUM_IRQ-1, edge-detect history = 0.
REQ-029 Reset mid-service SHALL discard all pending and in-service state; first request after release follows REQ-021 latency.

Structure
REQ-030 Shared package pic_pkg SHALL hold the IDW clog2 function and the default NUM_IRQ constant.
REQ-031 One sub-module prio_find SHALL perform rotate-by-lowest_prio plus find-first, returning valid and ID; instantiated twice, candidates and isr.

Verification
REQ-032 Reset, NUM_IRQ=8, irq_req=0x28, imr=0 -> int_req=1, int_id=3 two cycles later.
REQ-033 isr=0x08 held, irq_req=0x20 -> int_req stays 0; irq_req=0x04 -> int_id=2.
REQ-034 rotate_mode=1, service IR0 then eoi -> lowest_prio=0; irq_req=0x81 -> int_id=1? no, int_id=7.
REQ-035 Edge mode: irq_req[5] pulsed one cycle, then held 0 -> int_id=5 until ack; after ack, irr=0, isr=0x20.
REQ-036 special_mask=1, isr=0x01, irq_req=0x02 -> int_id=1; same with special_mask=0 -> int_req=0.
REQ-037 ack, eoi and set_prio(prio_id=4) in one cycle with isr=0x01, int_id=2 -> isr=0x04, lowest_prio=4; rst_n low mid-cycle -> all outputs reset immediately.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared constants and helpers for the rotating priority resolver.
// Priority ranks are measured from the level just after the current lowest-priority level.
package pic_pkg;

    localparam int DEFAULT_NUM_IRQ = 8;

    // Width needed to hold a level ID. It is never less than one bit.
    function automatic int id_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Callers guarantee that v < 2*n, so a single subtraction is enough.
    function automatic int wrap_id(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

    // Rank 0 is the highest priority. This is the level just after lowest.
    function automatic int prio_rank(input int id, input int lowest, input int n);
        int r;
        r = id - lowest - 1;
        if (r < 0) r += n;
        return r;
    endfunction

endpackage

// File: rtl/prio_find.sv
// Rotates a request vector so that level lowest+1 sits at bit 0, then finds the first set bit.
// Returns whether any bit was set, and the original level ID of the winning bit.
module prio_find
    import pic_pkg::*;
#(
    parameter int N   = DEFAULT_NUM_IRQ,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   vec,
    input  logic [IDW-1:0] lowest,
    output logic           valid,
    output logic [IDW-1:0] id
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;

    assign doubled = {vec, vec};
    assign rotated = N'(doubled >> (int'(lowest) + 1));

    // The scan runs downward, so the lowest set rotated bit is the last one written and wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                valid = 1'b1;
                id    = IDW'(wrap_id(int'(lowest) + 1 + k, N));
            end
        end
    end

endmodule

// File: rtl/rotating_priority_resolver.sv
// An 8259-style interrupt priority resolver with IRR, ISR, and the mask.
// It supports fully nested or automatic-rotation priority, specific and non-specific EOI, and special mask.
module rotating_priority_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ   = DEFAULT_NUM_IRQ,
    parameter int EDGE_TRIG = 0,
    localparam int IDW      = id_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               rotate_mode,
    input  logic               special_mask,
    input  logic               ack,
    input  logic               eoi,
    input  logic               seoi,
    input  logic [IDW-1:0]     seoi_id,
    input  logic               set_prio,
    input  logic [IDW-1:0]     prio_id,
    output logic               int_req,
    output logic [IDW-1:0]     int_id,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [IDW-1:0]     lowest_prio
);

    logic [NUM_IRQ-1:0] irq_hist;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] grant;
    logic [NUM_IRQ-1:0] irr_next;
    logic [NUM_IRQ-1:0] isr_next;
    logic [IDW-1:0]     lowest_next;
    logic               cand_valid;
    logic               isr_valid;
    logic [IDW-1:0]     cand_id;
    logic [IDW-1:0]     isr_id;
    logic               present;
    logic               ack_take;
    logic               seoi_ok;
    logic               prio_ok;

    assign cand     = irr & ~imr;
    assign ack_take = ack && int_req;
    assign seoi_ok  = seoi && (int'(seoi_id) < NUM_IRQ);
    assign prio_ok  = set_prio && (int'(prio_id) < NUM_IRQ);

    prio_find #(.N(NUM_IRQ), .IDW(IDW)) u_cand_find (
        .vec    (cand),
        .lowest (lowest_prio),
        .valid  (cand_valid),
        .id     (cand_id)
    );

    prio_find #(.N(NUM_IRQ), .IDW(IDW)) u_isr_find (
        .vec    (isr),
        .lowest (lowest_prio),
        .valid  (isr_valid),
        .id     (isr_id)
    );

    // An in-service level blocks every candidate of equal or lower priority, unless special mask is set.
    assign present = cand_valid &&
                     (special_mask || !isr_valid ||
                      (prio_rank(int'(cand_id), int'(lowest_prio), NUM_IRQ) <
                       prio_rank(int'(isr_id), int'(lowest_prio), NUM_IRQ)));

    always_comb begin
        grant = '0;
        if (ack_take) grant[int_id] = 1'b1;
    end

    always_comb begin
        if (EDGE_TRIG != 0) irr_next = (irr & ~grant) | (irq_req & ~irq_hist);
        else                irr_next = irq_req & ~grant;
    end

    // EOI clears act on the current ISR before the ack sets its bit. An explicit set_prio beats rotation.
    always_comb begin
        isr_next    = isr;
        lowest_next = lowest_prio;
        if (eoi && isr_valid) begin
            isr_next[isr_id] = 1'b0;
            if (rotate_mode) lowest_next = isr_id;
        end
        if (seoi_ok) isr_next[seoi_id] = 1'b0;
        if (ack_take) isr_next[int_id] = 1'b1;
        if (prio_ok) lowest_next = prio_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr         <= '0;
            isr         <= '0;
            irq_hist    <= '0;
            lowest_prio <= IDW'(NUM_IRQ - 1);
            int_req     <= 1'b0;
            int_id      <= '0;
        end else begin
            irr         <= irr_next;
            isr         <= isr_next;
            irq_hist    <= irq_req;
            lowest_prio <= lowest_next;
            if (ack_take) begin
                int_req <= 1'b0;
                int_id  <= '0;
            end else begin
                int_req <= present;
                int_id  <= present ? cand_id : '0;
            end
        end
    end

endmodule

// File: tb/tb_rotating_priority_resolver.sv
// Directed testbench for rotating_priority_resolver, with one level-triggered and one edge-triggered instance.
// The expected values are worked out by hand from the resolver's priority rules.
module tb_rotating_priority_resolver;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_req, irq_e, imr;
    logic       rotate_mode, special_mask, ack, ack_e, eoi, seoi, set_prio;
    logic [2:0] seoi_id, prio_id;

    logic       int_req, int_req_e;
    logic [2:0] int_id, int_id_e, lowest_prio, lowest_e;
    logic [7:0] irr, isr, irr_e, isr_e;

    int total;
    int bad;

    rotating_priority_resolver #(.NUM_IRQ(8), .EDGE_TRIG(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_req      (irq_req),
        .imr          (imr),
        .rotate_mode  (rotate_mode),
        .special_mask (special_mask),
        .ack          (ack),
        .eoi          (eoi),
        .seoi         (seoi),
        .seoi_id      (seoi_id),
        .set_prio     (set_prio),
        .prio_id      (prio_id),
        .int_req      (int_req),
        .int_id       (int_id),
        .irr          (irr),
        .isr          (isr),
        .lowest_prio  (lowest_prio)
    );

    rotating_priority_resolver #(.NUM_IRQ(8), .EDGE_TRIG(1)) dut_e (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_req      (irq_e),
        .imr          (imr),
        .rotate_mode  (rotate_mode),
        .special_mask (special_mask),
        .ack          (ack_e),
        .eoi          (eoi),
        .seoi         (seoi),
        .seoi_id      (seoi_id),
        .set_prio     (set_prio),
        .prio_id      (prio_id),
        .int_req      (int_req_e),
        .int_id       (int_id_e),
        .irr          (irr_e),
        .isr          (isr_e),
        .lowest_prio  (lowest_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        irq_req = '0; irq_e = '0; imr = '0;
        rotate_mode = 1'b0; special_mask = 1'b0;
        ack = 1'b0; ack_e = 1'b0; eoi = 1'b0; seoi = 1'b0; set_prio = 1'b0;
        seoi_id = '0; prio_id = '0;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        clearInputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clearInputs();
        tick();
        tick();
        checkOutput("rst_int_req", 32'(int_req), 32'd0);
        checkOutput("rst_int_id", 32'(int_id), 32'd0);
        checkOutput("rst_irr", 32'(irr), 32'h00);
        checkOutput("rst_isr", 32'(isr), 32'h00);
        checkOutput("rst_lowest", 32'(lowest_prio), 32'd7);
        checkOutput("rst_lowest_e", 32'(lowest_e), 32'd7);
        rst_n = 1'b1;

        // Two requests arrive together, and level 3 wins over level 5.
        irq_req = 8'h28;
        tick();
        checkOutput("lat1_irr", 32'(irr), 32'h28);
        checkOutput("lat1_int_req", 32'(int_req), 32'd0);
        tick();
        checkOutput("lat2_int_req", 32'(int_req), 32'd1);
        checkOutput("lat2_int_id", 32'(int_id), 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("ack_isr", 32'(isr), 32'h08);
        checkOutput("ack_irr", 32'(irr), 32'h20);
        checkOutput("ack_int_req", 32'(int_req), 32'd0);

        // With level 3 in service, level 5 is blocked but level 2 is not.
        irq_req = 8'h20;
        tick();
        tick();
        checkOutput("nest_block", 32'(int_req), 32'd0);
        irq_req = 8'h04;
        tick();
        tick();
        checkOutput("nest_pass_req", 32'(int_req), 32'd1);
        checkOutput("nest_pass_id", 32'(int_id), 32'd2);

        // Assert reset asynchronously in the middle of a cycle while an interrupt is in service.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_isr", 32'(isr), 32'h00);
        checkOutput("async_irr", 32'(irr), 32'h00);
        checkOutput("async_int_req", 32'(int_req), 32'd0);
        checkOutput("async_int_id", 32'(int_id), 32'd0);
        checkOutput("async_lowest", 32'(lowest_prio), 32'd7);
        irq_req = 8'h00;
        tick();
        rst_n = 1'b1;
        irq_req = 8'h10;
        tick();
        checkOutput("post_rst_lat1", 32'(int_req), 32'd0);
        tick();
        checkOutput("post_rst_req", 32'(int_req), 32'd1);
        checkOutput("post_rst_id", 32'(int_id), 32'd4);

        // Rotation: serve IR0, then a non-specific EOI makes IR0 the lowest priority.
        resetDut();
        rotate_mode = 1'b1;
        irq_req = 8'h01;
        tick();
        tick();
        checkOutput("rot_id0", 32'(int_id), 32'd0);
        ack = 1'b1;
        irq_req = 8'h00;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        checkOutput("rot_isr", 32'(isr), 32'h00);
        checkOutput("rot_lowest", 32'(lowest_prio), 32'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        checkOutput("eoi_empty_lowest", 32'(lowest_prio), 32'd0);
        irq_req = 8'h81;
        tick();
        tick();
        checkOutput("rot_req", 32'(int_req), 32'd1);
        checkOutput("rot_id7", 32'(int_id), 32'd7);

        // A masked level drops out of the candidate set.
        resetDut();
        imr = 8'h08;
        irq_req = 8'h28;
        tick();
        tick();
        checkOutput("mask_id", 32'(int_id), 32'd5);

        // Special mask lets a lower level through while IR0 is in service.
        resetDut();
        irq_req = 8'h01;
        tick();
        tick();
        ack = 1'b1;
        irq_req = 8'h02;
        tick();
        ack = 1'b0;
        tick();
        tick();
        checkOutput("smm_off_isr", 32'(isr), 32'h01);
        checkOutput("smm_off_req", 32'(int_req), 32'd0);
        special_mask = 1'b1;
        tick();
        checkOutput("smm_on_req", 32'(int_req), 32'd1);
        checkOutput("smm_on_id", 32'(int_id), 32'd1);

        // Ack, EOI and set_prio all arrive in the same cycle.
        resetDut();
        special_mask = 1'b1;
        irq_req = 8'h01;
        tick();
        tick();
        ack = 1'b1;
        irq_req = 8'h04;
        tick();
        ack = 1'b0;
        tick();
        checkOutput("combo_pre_id", 32'(int_id), 32'd2);
        checkOutput("combo_pre_isr", 32'(isr), 32'h01);
        ack = 1'b1;
        eoi = 1'b1;
        set_prio = 1'b1;
        prio_id = 3'd4;
        rotate_mode = 1'b1;
        tick();
        clearInputs();
        checkOutput("combo_isr", 32'(isr), 32'h04);
        checkOutput("combo_lowest", 32'(lowest_prio), 32'd4);
        checkOutput("combo_int_req", 32'(int_req), 32'd0);

        // In edge mode, a one-cycle pulse on line 5 stays latched until it is acked.
        resetDut();
        irq_e = 8'h20;
        tick();
        irq_e = 8'h00;
        checkOutput("edge_irr", 32'(irr_e), 32'h20);
        checkOutput("edge_lat1", 32'(int_req_e), 32'd0);
        tick();
        checkOutput("edge_req", 32'(int_req_e), 32'd1);
        checkOutput("edge_id", 32'(int_id_e), 32'd5);
        tick();
        tick();
        checkOutput("edge_hold_id", 32'(int_id_e), 32'd5);
        ack_e = 1'b1;
        tick();
        ack_e = 1'b0;
        checkOutput("edge_ack_irr", 32'(irr_e), 32'h00);
        checkOutput("edge_ack_isr", 32'(isr_e), 32'h20);
        checkOutput("edge_ack_req", 32'(int_req_e), 32'd0);
        seoi = 1'b1;
        seoi_id = 3'd5;
        tick();
        seoi = 1'b0;
        checkOutput("seoi_isr", 32'(isr_e), 32'h00);
        checkOutput("seoi_lowest", 32'(lowest_e), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
